bus_arbiter: RTL and testbench

Parametrised, registered bus for the datapath. It generalises the fixed 24-source priority bus with configurable width, source count, fixed-priority or round-robin arbitration, and bus locking. One bus source is selected per clock from a request vector, and the granted source's data is driven onto a registered output that holds its last value when idle. Multi-request conflicts are flagged and counted for debug.

---
 rtl/bus_arbiter.sv | 103 ++++++++++
 tb/tb_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Parametrised registered bus arbiter: fixed-priority or round-robin selection,
// bus lock, and a saturating multi-request conflict counter.
module bus_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NSRC    = 24,
   parameter int RR_MODE = 0,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NSRC-1:0]         req,
   input  logic [NSRC*WIDTH-1:0]   data_in,
   input  logic                    lock,
   output logic [NSRC-1:0]         grant,
   output logic [WIDTH-1:0]        bus_out,
   output logic                    bus_valid,
   output logic                    conflict,
   output logic [CNT_W-1:0]        conflict_cnt
);

   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam logic [NSRC-1:0] ONE = {{(NSRC-1){1'b0}}, 1'b1};

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    g_idx;
   logic [PW-1:0]    win;
   logic [PW-1:0]    cand;
   logic [PW-1:0]    sel;
   logic             found;
   logic             hold;
   logic             multi;
   logic [WIDTH-1:0] sel_data;
   logic [NSRC-1:0]  next_grant;

   always_comb begin : arb
      int pos;
      pos        = 0;
      cand       = '0;
      g_idx      = '0;
      win        = '0;
      found      = 1'b0;
      sel_data   = '0;
      next_grant = '0;

      // grant is one-hot, so any overlap with req means the grantee still requests
      hold = lock && ((grant & req) != '0);

      for (int i = 0; i < NSRC; i++) begin
         if (grant[i]) g_idx = PW'(i);
      end

      if (RR_MODE == 0) begin
         for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
               found = 1'b1;
               win   = PW'(i);
            end
         end
      end else begin
         // search wraps modulo NSRC, not modulo 2^PW
         for (int i = 0; i < NSRC; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NSRC) pos = pos - NSRC;
            cand = PW'(pos);
            if (!found && req[cand]) begin
               found = 1'b1;
               win   = cand;
            end
         end
      end

      sel = hold ? g_idx : win;
      for (int i = 0; i < NSRC; i++) begin
         if (sel == PW'(i)) sel_data = data_in[i*WIDTH +: WIDTH];
      end

      if (hold)       next_grant = grant;
      else if (found) next_grant = ONE << win;

      multi = |(req & (req - ONE));
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         grant        <= '0;
         bus_out      <= '0;
         bus_valid    <= 1'b0;
         conflict     <= 1'b0;
         conflict_cnt <= '0;
         ptr          <= '0;
      end else begin
         grant     <= next_grant;
         bus_valid <= hold | found;
         if (hold | found) bus_out <= sel_data;
         conflict <= multi;
         if (multi && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         if ((RR_MODE != 0) && !hold && found)
            ptr <= (win == PW'(NSRC - 1)) ? '0 : win + PW'(1);
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three configurations driven by shared stimulus and
// checked every cycle against a behavioural model, plus directed scenarios.
module tb_bus_arbiter;

   localparam int N = 24;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           clr;
   logic           lock;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;

   logic [N-1:0] g0, g1, g2;
   logic [W-1:0] b0, b1, b2;
   logic         v0, v1, v2, c0, c1, c2;
   logic [7:0]   n0, n1;
   logic [1:0]   n2;

   int n_tests = 0;
   int n_fail  = 0;

   int         mg[3];
   int         mp[3];
   logic [W-1:0] mb[3];
   logic       mv[3];
   logic       mc[3];
   int         mcnt[3];

   always #5 clk = ~clk;

   bus_arbiter #(.WIDTH(W), .NSRC(N), .RR_MODE(0), .CNT_W(8)) dut_fp (
      .clk(clk), .clr(clr), .req(req), .data_in(data_in), .lock(lock),
      .grant(g0), .bus_out(b0), .bus_valid(v0), .conflict(c0), .conflict_cnt(n0));

   bus_arbiter #(.WIDTH(W), .NSRC(N), .RR_MODE(1), .CNT_W(8)) dut_rr (
      .clk(clk), .clr(clr), .req(req), .data_in(data_in), .lock(lock),
      .grant(g1), .bus_out(b1), .bus_valid(v1), .conflict(c1), .conflict_cnt(n1));

   bus_arbiter #(.WIDTH(W), .NSRC(N), .RR_MODE(0), .CNT_W(2)) dut_sat (
      .clk(clk), .clr(clr), .req(req), .data_in(data_in), .lock(lock),
      .grant(g2), .bus_out(b2), .bus_valid(v2), .conflict(c2), .conflict_cnt(n2));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: who owns the bus, from the arbitration rules alone
   task automatic model_step(input int k, input int mode, input int cmax);
      int c;
      if (clr) begin
         mg[k] = -1; mp[k] = 0; mb[k] = '0; mv[k] = 1'b0; mc[k] = 1'b0; mcnt[k] = 0;
      end else begin
         if (lock && mg[k] >= 0 && req[mg[k]]) begin
            mg[k] = mg[k];
         end else if (req == '0) begin
            mg[k] = -1;
         end else if (mode == 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) mg[k] = i;
         end else begin
            for (int j = 0; j < N; j++) begin
               c = (mp[k] + j) % N;
               if (req[c]) begin
                  mg[k] = c;
                  break;
               end
            end
            mp[k] = (mg[k] + 1) % N;
         end
         if (mg[k] >= 0) begin
            mb[k] = data_in[mg[k]*W +: W];
            mv[k] = 1'b1;
         end else begin
            mv[k] = 1'b0;
         end
         mc[k] = ($countones(req) >= 2);
         if (mc[k] && mcnt[k] < cmax) mcnt[k]++;
      end
   endtask

   task automatic check_dut(input string nm, input int k, input logic [N-1:0] g,
                            input logic [W-1:0] b, input logic v, input logic c,
                            input logic [7:0] n);
      logic [63:0] eg;
      eg = (mg[k] >= 0) ? (64'd1 << mg[k]) : 64'd0;
      chk({nm, "_grant"}, 64'(g), eg);
      chk({nm, "_bus"},   64'(b), 64'(mb[k]));
      chk({nm, "_valid"}, 64'(v), 64'(mv[k]));
      chk({nm, "_conf"},  64'(c), 64'(mc[k]));
      chk({nm, "_cnt"},   64'(n), 64'(mcnt[k]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0, 0, 255);
      model_step(1, 1, 255);
      model_step(2, 0, 3);
      @(negedge clk);
      check_dut("fp",  0, g0, b0, v0, c0, n0);
      check_dut("rr",  1, g1, b1, v1, c1, n1);
      check_dut("sat", 2, g2, b2, v2, c2, {6'd0, n2});
   endtask

   initial begin
      int rr_seq[5];
      int r;
      rr_seq = '{0, 5, 23, 0, 5};
      for (int k = 0; k < 3; k++) begin
         mg[k] = -1; mp[k] = 0; mb[k] = '0; mv[k] = 0; mc[k] = 0; mcnt[k] = 0;
      end
      clr = 1'b1; lock = 1'b0; req = '1; data_in = '0;

      // reset with all requests pending
      cycle();
      cycle();
      chk("rst_grant", 64'(g0 | g1 | g2), 64'd0);
      chk("rst_bus",   64'(b0 | b1 | b2), 64'd0);
      chk("rst_cnt",   64'(n0 | n1 | {6'd0, n2}), 64'd0);

      clr = 1'b0; req = 24'h000004; data_in[2*W +: W] = 32'hDEADBEEF;
      cycle();
      chk("first_grant", 64'(g0), 64'h4);
      chk("first_bus",   64'(b0), 64'hDEADBEEF);
      chk("first_valid", 64'(v0), 64'd1);

      // fixed priority between sources 9 and 11
      req = 24'h000A00; data_in[9*W +: W] = 32'h9; data_in[11*W +: W] = 32'hB;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         chk("fp_grant", 64'(g0), 64'h200);
         chk("fp_bus",   64'(b0), 64'h9);
         chk("fp_conf",  64'(c0), 64'd1);
         chk("fp_cnt",   64'(n0), 64'(i));
      end

      // round-robin wrap across sources 0, 5, 23
      clr = 1'b1; cycle(); clr = 1'b0;
      req = '0; req[0] = 1'b1; req[5] = 1'b1; req[23] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("rr_seq", 64'(g1), 64'd1 << rr_seq[i]);
      end

      // lock hold on source 3 while 4 also requests
      req = 24'h000008; data_in[3*W +: W] = 32'h0;
      cycle();
      chk("lk_pre", 64'(g0), 64'h8);
      lock = 1'b1; req = 24'h000018;
      for (int i = 1; i <= 4; i++) begin
         data_in[3*W +: W] = 32'(i);
         data_in[4*W +: W] = 32'h4444_0000 + 32'(i);
         cycle();
         chk("lk_grant", 64'(g0), 64'h8);
         chk("lk_bus",   64'(b0), 64'(i));
         chk("lk_rr",    64'(g1), 64'h8);
      end
      req = 24'h000010;
      cycle();
      chk("lk_rel", 64'(g0), 64'h10);
      lock = 1'b0;

      // idle hold
      req = 24'h000080; data_in[7*W +: W] = 32'h12345678;
      cycle();
      req = '0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("idle_grant", 64'(g0), 64'd0);
         chk("idle_valid", 64'(v0), 64'd0);
         chk("idle_bus",   64'(b0), 64'h12345678);
      end

      // saturation with 2-bit counter
      clr = 1'b1; cycle(); clr = 1'b0;
      req = 24'h000003;
      for (int i = 1; i <= 6; i++) begin
         cycle();
         chk("sat_cnt", 64'(n2), 64'((i > 3) ? 3 : i));
      end

      // reset in the middle of a lock hold
      req = 24'h000004; lock = 1'b1;
      cycle();
      cycle();
      clr = 1'b1;
      cycle();
      chk("mid_grant", 64'(g0 | g2), 64'd0);
      chk("mid_bus",   64'(b0 | b2), 64'd0);
      chk("mid_valid", 64'(v0 | v2), 64'd0);
      chk("mid_cnt",   64'(n0 | {6'd0, n2}), 64'd0);
      clr = 1'b0;
      cycle();
      chk("post_grant", 64'(g0), 64'h4);
      lock = 1'b0;

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         clr  = ($urandom_range(0, 39) == 0);
         lock = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 3);
         case (r)
            0: req = '0;
            1: req = 24'd1 << $urandom_range(0, N - 1);
            2: req = N'($urandom) & N'($urandom) & N'($urandom);
            default: req = N'($urandom);
         endcase
         for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
